// File: rtl/traffic_light_sched.sv
// N-lane round-robin traffic-light scheduler with tick-timed phases, all-red
// clearance, bounded congestion extensions and emergency pre-emption.
module traffic_light_sched #(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned EXT_TICKS    = 10,
  parameter int unsigned MAX_EXT      = 2,
  localparam int unsigned LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NUM_LANES-1:0] req,
  input  logic [NUM_LANES-1:0] cong,
  input  logic                 emg_req,
  input  logic [LANE_W-1:0]    emg_lane,
  output logic [NUM_LANES-1:0] green,
  output logic [NUM_LANES-1:0] yellow,
  output logic [1:0]           phase,
  output logic [LANE_W-1:0]    lane,
  output logic [CNT_W-1:0]     ext_cnt
);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_t;

  phase_t             state;
  logic [CNT_W-1:0]   timer;
  logic               emg_valid;
  logic               emg_other;
  logic               expire;
  logic               can_extend;
  logic               sel_valid;
  logic [LANE_W-1:0]  sel_lane;
  logic [LANE_W-1:0]  scan_idx;
  logic               grant;
  logic [LANE_W-1:0]  next_lane;

  function automatic logic [NUM_LANES-1:0] onehot(input logic [LANE_W-1:0] l);
    return NUM_LANES'(1) << l;
  endfunction

  assign phase = state;

  // Qualified events for the phase logic
  always_comb begin
    emg_valid  = emg_req && (32'(emg_lane) < NUM_LANES);
    emg_other  = emg_valid && (emg_lane != lane);
    expire     = tick && (timer == '0);
    can_extend = cong[lane] && (32'(ext_cnt) < MAX_EXT);
  end

  // Round-robin scan starting after the last-served lane; last iteration wins,
  // so descending order leaves the nearest requester selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_lane  = '0;
    scan_idx  = '0;
    for (int unsigned k = NUM_LANES; k >= 1; k--) begin
      scan_idx = LANE_W'((32'(lane) + k) % NUM_LANES);
      if (req[scan_idx]) begin
        sel_valid = 1'b1;
        sel_lane  = scan_idx;
      end
    end
    grant     = emg_valid || sel_valid;
    next_lane = emg_valid ? emg_lane : sel_lane;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ALLRED;
      timer   <= CNT_W'(ALLRED_TICKS - 1);
      lane    <= LANE_W'(NUM_LANES - 1);
      ext_cnt <= '0;
      green   <= '0;
      yellow  <= '0;
    end else begin
      case (state)
        ALLRED: begin
          if (expire) begin
            // With no grant the timer stays at 0 and arbitration retries next tick
            if (grant) begin
              state   <= GREEN;
              lane    <= next_lane;
              timer   <= CNT_W'(GREEN_TICKS - 1);
              ext_cnt <= '0;
              green   <= onehot(next_lane);
            end
          end else if (tick) begin
            timer <= timer - CNT_W'(1);
          end
        end
        GREEN: begin
          if (emg_other) begin
            state  <= YELLOW;
            timer  <= CNT_W'(YELLOW_TICKS - 1);
            green  <= '0;
            yellow <= onehot(lane);
          end else if (tick) begin
            if (timer != '0) begin
              timer <= timer - CNT_W'(1);
            end else if (!emg_valid) begin
              // A valid emergency here targets this lane: hold green at 0
              if (can_extend) begin
                timer   <= CNT_W'(EXT_TICKS - 1);
                ext_cnt <= ext_cnt + CNT_W'(1);
              end else begin
                state  <= YELLOW;
                timer  <= CNT_W'(YELLOW_TICKS - 1);
                green  <= '0;
                yellow <= onehot(lane);
              end
            end
          end
        end
        YELLOW: begin
          if (expire) begin
            state  <= ALLRED;
            timer  <= CNT_W'(ALLRED_TICKS - 1);
            yellow <= '0;
          end else if (tick) begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: begin
          state  <= ALLRED;
          timer  <= CNT_W'(ALLRED_TICKS - 1);
          green  <= '0;
          yellow <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_sched.sv
// Bench for traffic_light_sched: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a duration-based model.
module tb_traffic_light_sched;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int G  = 3;
  localparam int Y  = 2;
  localparam int A  = 1;
  localparam int E  = 2;
  localparam int MX = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] cong = '0;
  logic         emg_req = 1'b0;
  logic [1:0]   emg_lane = '0;
  logic [N-1:0] green;
  logic [N-1:0] yellow;
  logic [1:0]   phase;
  logic [1:0]   lane;
  logic [CW-1:0] ext_cnt;

  int total = 0;
  int bad   = 0;

  traffic_light_sched #(
    .NUM_LANES(N), .CNT_W(CW), .GREEN_TICKS(G), .YELLOW_TICKS(Y),
    .ALLRED_TICKS(A), .EXT_TICKS(E), .MAX_EXT(MX)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .cong(cong),
    .emg_req(emg_req), .emg_lane(emg_lane), .green(green), .yellow(yellow),
    .phase(phase), .lane(lane), .ext_cnt(ext_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: phase kind, ticks remaining in the phase, served lane, extensions.
  int m_phase = 0;
  int m_rem   = A;
  int m_lane  = N - 1;
  int m_ext   = 0;

  always @(posedge clk or posedge rst) begin
    int  pick;
    bit  ev;
    if (rst) begin
      m_phase = 0; m_rem = A; m_lane = N - 1; m_ext = 0;
    end else begin
      ev = emg_req && (int'(emg_lane) < N);
      case (m_phase)
        0: if (tick) begin
          if (m_rem > 1) m_rem--;
          else begin
            pick = -1;
            if (ev) pick = int'(emg_lane);
            else
              for (int k = 1; k <= N; k++)
                if (pick < 0 && req[(m_lane + k) % N]) pick = (m_lane + k) % N;
            if (pick >= 0) begin
              m_phase = 1; m_lane = pick; m_rem = G; m_ext = 0;
            end else m_rem = 1;
          end
        end
        1: if (ev && int'(emg_lane) != m_lane) begin
          m_phase = 2; m_rem = Y;
        end else if (tick) begin
          if (m_rem > 1) m_rem--;
          else if (ev) m_rem = 1;
          else if (cong[m_lane] && m_ext < MX) begin
            m_rem = E; m_ext++;
          end else begin
            m_phase = 2; m_rem = Y;
          end
        end
        default: if (tick) begin
          if (m_rem > 1) m_rem--;
          else begin m_phase = 0; m_rem = A; end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    int eg, ey;
    eg = (m_phase == 1) ? (1 << m_lane) : 0;
    ey = (m_phase == 2) ? (1 << m_lane) : 0;
    check("phase", int'(phase), m_phase);
    check("lane", int'(lane), m_lane);
    check("ext_cnt", int'(ext_cnt), m_ext);
    check("green", int'(green), eg);
    check("yellow", int'(yellow), ey);
    check("onehot", ($countones(green | yellow) <= 1) ? 1 : 0, 1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;

    // Idle: no requests keeps all-red
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_phase", int'(phase), 0);
      check("idle_lamps", int'(green | yellow), 0);
    end

    // Round robin between lanes 0 and 2
    req = 4'b0101;
    step(1);  check("rr_g0", int'(green), 1);
    step(3);  check("rr_y0", int'(yellow), 1);
    step(2);  check("rr_ar", int'(phase), 0);
    step(1);  check("rr_g2", int'(green), 4);
    step(6);  check("rr_back0", int'(green), 1);

    // Congestion extensions, capped at two
    do_reset();
    req = 4'b0001; cong = 4'b0001;
    step(1);  check("ext0", int'(ext_cnt), 0);
    step(3);  check("ext1", int'(ext_cnt), 1);
              check("ext1_g", int'(green), 1);
    step(2);  check("ext2", int'(ext_cnt), 2);
    step(1);  check("ext2_g", int'(green), 1);
    step(1);  check("ext_y", int'(yellow), 1);
              check("ext_cap", int'(ext_cnt), 2);
    cong = '0;

    // Emergency abort of lane 0, hold on lane 2, then release
    do_reset();
    req = 4'b0001;
    step(1);  check("emg_g0", int'(green), 1);
    emg_req = 1'b1; emg_lane = 2'd2;
    step(1);  check("emg_abort", int'(yellow), 1);
    step(3);  check("emg_g2", int'(green), 4);
    step(10); check("emg_hold", int'(green), 4);
    emg_req = 1'b0;
    step(1);  check("emg_rel", int'(yellow), 4);

    // Tick freeze mid-green
    do_reset();
    req = 4'b0001;
    step(2);
    tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("frz_g", int'(green), 1);
    end
    tick = 1'b1;
    step(1);  check("frz_last", int'(green), 1);
    step(1);  check("frz_y", int'(yellow), 1);

    // Asynchronous reset mid-yellow
    #2 rst = 1'b1;
    #1;
    check("arst_lamps", int'(green | yellow), 0);
    check("arst_phase", int'(phase), 0);
    check("arst_lane", int'(lane), 3);
    #3 rst = 1'b0;
    req = 4'b1111;
    step(1);  check("arst_first", int'(green), 1);
              check("arst_lane0", int'(lane), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      req  = N'($urandom);
      cong = N'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        emg_req  = ~emg_req;
        emg_lane = 2'($urandom);
      end
      step(1);
    end

    emg_req = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_sched.md
Name: traffic_light_sched

Overview:
Parametrised N-lane traffic-light scheduler. It is the successor to the fixed 4-lane controller and adds per-phase tick-timed durations, an all-red clearance phase, bounded congestion extensions and emergency pre-emption. The block sits between the lane sensor front-end (start and congestion sensors) and the lamp drivers. It runs off a shared time-base enable.

Parameters:
NUM_LANES, 4, number of lanes served round-robin; must be at least 2.
CNT_W, 8, phase timer width; every duration must be at most 2^CNT_W.
GREEN_TICKS, 20, base green duration in ticks; must be at least 1.
YELLOW_TICKS, 4, yellow duration in ticks; must be at least 1.
ALLRED_TICKS, 2, all-red clearance duration in ticks; must be at least 1.
EXT_TICKS, 10, duration added per congestion extension, in ticks; must be at least 1.
MAX_EXT, 2, maximum number of extensions per green; 0 disables extensions.
Localparam LANE_W = max(1, clog2(NUM_LANES)).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
tick  in  1  time-base enable; timers advance only on cycles where tick is 1.
req  in  NUM_LANES  start sensors; bit i set means a vehicle is waiting on lane i.
cong  in  NUM_LANES  congestion sensors; bit i set means lane i is congested.
emg_req  in  1  emergency pre-emption request (level).
emg_lane  in  LANE_W  lane to pre-empt for; only valid while emg_req is 1.
green  out  NUM_LANES  one-hot green lamp; all zero when no lane is green.
yellow  out  NUM_LANES  one-hot yellow lamp.
phase  out  2  0 = ALLRED, 1 = GREEN, 2 = YELLOW; 3 is never driven.
lane  out  LANE_W  lane currently or last served.
ext_cnt  out  CNT_W  extensions granted in the current green.

Behaviour:
- Clocking and reset: all outputs are registered and update on the same edge as the state.
  - On rst: phase=ALLRED, timer=ALLRED_TICKS-1, lane=NUM_LANES-1 (so lane 0 wins first), ext_cnt=0, green=0, yellow=0.
  - rst acts asynchronously, including mid-phase.
- Phase timer:
  - On phase entry the timer loads DUR-1.
  - A tick with timer not 0 decrements it.
  - A tick with timer equal to 0 is "expire": the phase ends on that edge.
  - A phase therefore lasts exactly DUR ticks. With tick=0 the state is frozen (emergency abort excepted).
- ALLRED expire, arbitration in priority order:
  - If emg_req is set and emg_lane < NUM_LANES, select emg_lane.
  - Otherwise select the first set req bit scanning lane+1, lane+2, ... with wrap-around modulo NUM_LANES. The current lane is scanned last.
  - If a lane is selected: enter GREEN, set lane to it, timer=GREEN_TICKS-1, ext_cnt=0.
  - If nothing is selected: stay in ALLRED with timer=0, so arbitration repeats every tick.
- GREEN, with L = lane:
  - Emergency abort: if emg_req is set, emg_lane is valid and emg_lane != L, enter YELLOW on the next clk edge regardless of tick, with timer=YELLOW_TICKS-1.
  - Emergency hold: if emg_req is set and emg_lane == L, expire is suppressed (timer holds at 0) while emg_req stays high.
  - On expire, if cong[L]=1 and ext_cnt < MAX_EXT: stay in GREEN, timer=EXT_TICKS-1, ext_cnt+1.
  - On expire otherwise: enter YELLOW, timer=YELLOW_TICKS-1.
  - cong is sampled only at expire.
- YELLOW expire: enter ALLRED, timer=ALLRED_TICKS-1. lane is kept and becomes the round-robin pointer. emg_req does not shorten yellow.
- Invalid input: emg_lane >= NUM_LANES is treated as emg_req=0.
- Invariants:
  - At most one bit of green|yellow is set.
  - green[L]=1 only in GREEN; yellow[L]=1 only in YELLOW; both are zero in ALLRED.
  - ext_cnt is never greater than MAX_EXT.
- Simultaneous events:
  - Emergency abort takes precedence over extension or expire on the same cycle.
  - A req deasserting during GREEN does not shorten the phase.

Test Plan:
Bench config for all scenarios: NUM_LANES=4, GREEN_TICKS=3, YELLOW_TICKS=2, ALLRED_TICKS=1, EXT_TICKS=2, MAX_EXT=2, tick=1 unless stated.
1. Reset with req=0000 for 20 cycles -> phase=0, green=0000 and yellow=0000 on every cycle.
2. req=0101 held -> 1 cycle ALLRED, then green=0001 for 3 cycles, yellow=0001 for 2, ALLRED for 1, then green=0100 for 3, then back to lane 0.
3. req=0001, cong=0001 held -> green=0001 for 7 cycles (3+2+2), ext_cnt steps 0 to 1 to 2, then yellow=0001; a third extension is never granted.
4. Lane 0 in green cycle 1, then emg_req=1, emg_lane=2 held -> next edge yellow=0001 (2 cycles), ALLRED (1), then green=0100 held indefinitely. Dropping emg_req -> yellow within 1 cycle, because the timer is already 0.
5. tick=0 for 10 cycles mid-green -> green and timer unchanged. Restoring tick -> the remaining green duration completes.
6. rst pulse mid-yellow, not clock-aligned -> green=0, yellow=0, phase=0, lane=3 immediately. After release, the first served lane is lane 0 when req[0]=1.
